loop_filter_pi: RTL and testbench
=================================

LOOP_FILTER_PI -- requirements
Module: loop_filter_pi

Interface
REQ-001 SHALL have parameter ERR_W, default 16, meaning signed phase-error width.
REQ-002 SHALL have parameter ACC_W, default 24, meaning signed integrator width.
REQ-003 SHALL have parameter K_INT, default 8, meaning integer bits of each gain.
REQ-004 SHALL have parameter K_FRAC, default 8, meaning fractional bits of each gain.
REQ-005 SHALL have parameter OUT_W, default 16, meaning unsigned control-word width.
REQ-006 SHALL have port clk_ref, in, 1, meaning the single clock; all state changes on rising edge.
REQ-007 SHALL have port n_rst, in, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have port err_valid, in, 1, meaning error is a new sample this cycle.
REQ-009 SHALL have port error, in, ERR_W signed, meaning phase error.
REQ-010 SHALL have ports kp and ki, in, K_INT+K_FRAC signed each, meaning proportional and integral gains.
REQ-011 SHALL have port mode, in, 2, meaning 0 PI, 1 P_ONLY, 2 HOLD, 3 CLEAR.
REQ-012 SHALL have ports out_min and out_max, in, OUT_W unsigned each, meaning output clamp bounds.
REQ-013 SHALL have port lf_out, out, OUT_W, meaning registered control word.
REQ-014 SHALL have port lf_valid, out, 1, meaning one-cycle pulse when lf_out updates.
REQ-015 SHALL have ports sat_hi and sat_lo, out, 1 each, meaning the last lf_out was clamped to out_max or out_min.
REQ-016 SHALL have port acc_sat, out, 1, meaning the integrator is held at its rail.

Function
REQ-017 SHALL process samples only in cycles with err_valid=1; with err_valid=0, stage-1 registers, accumulator and mode effects SHALL be unchanged.
REQ-018 SHALL use a two-stage pipeline: lf_valid asserts exactly 2 cycles after err_valid; back-to-back samples are accepted every cycle.
REQ-019 Stage 1 SHALL register p = error*kp and i = acc_old*ki at full product width; acc_old is the accumulator before this sample's update.
REQ-019a In P_ONLY, CLEAR and HOLD, stage 1 SHALL use the same p; i SHALL be forced to 0 in P_ONLY and CLEAR.
REQ-020 Stage 2 SHALL form sum = p + i sign-extended one bit wider than the wider product, then arithmetic-shift right by K_FRAC (floor; -1 stays -1).
REQ-021 Stage 2 SHALL clamp: shifted < out_min (including negative) -> out_min with sat_lo=1; shifted > out_max -> out_max with sat_hi=1; else the low OUT_W bits with both flags 0.
REQ-022 If out_min > out_max, lf_out SHALL be out_min and sat_lo=1.
REQ-023 In PI mode, the accumulator SHALL update to acc_old + error, saturating at +(2^(ACC_W-1)-1) and -2^(ACC_W-1); acc_sat SHALL be 1 while it sits at either rail.
REQ-024 Anti-windup: the accumulator SHALL NOT update when sat_hi=1 and error>0, or when sat_lo=1 and error<0; sat_hi and sat_lo are the registered flags at the time of the sample.
REQ-025 In P_ONLY and HOLD, the accumulator SHALL be frozen; HOLD SHALL still use acc_old for i.
REQ-026 In CLEAR, the accumulator SHALL become 0 and acc_sat SHALL clear.
REQ-027 A mode change SHALL take effect on the first valid sample carrying the new mode; samples already in flight SHALL complete under their captured mode.

Reset
REQ-028 While n_rst=0, the accumulator, both pipeline stages, lf_out, lf_valid, sat_hi, sat_lo and acc_sat SHALL be 0 immediately, independent of clk_ref.
REQ-029 A reset mid-pipeline SHALL discard in-flight samples; no lf_valid pulse SHALL occur for them.
REQ-030 After release, the first lf_valid SHALL occur 2 cycles after the first err_valid.

Structure
REQ-031 A shared package lf_pkg SHALL hold the mode enum (PI, P_ONLY, HOLD, CLEAR) and the default width constants.
REQ-032 The clamp logic SHALL be one combinational sub-module, lf_clamp, also reused for the accumulator rail saturation.

Verification
REQ-033 Reset check: assert n_rst=0 mid-stream -> all outputs 0 asynchronously; no lf_valid until 2 cycles after the next err_valid.
REQ-034 Proportional path: kp=0x0100, ki=0, error=+100, PI, bounds [0,65535] -> lf_out=100, lf_valid exactly 2 cycles later, flags 0.
REQ-035 Low clamp: error=-50, kp=0x0100, out_min=0 -> lf_out=0, sat_lo=1; with out_min=10 -> lf_out=10.
REQ-036 Integral path: ki=0x0010, kp=0, error=+16 for 4 samples -> lf_out sequence 0,1,2,3.
REQ-037 Integrator rail: kp=ki=0, error=+32767 for 260 samples -> accumulator = 8388607 and acc_sat=1 from sample 257; then CLEAR -> accumulator 0, acc_sat=0.
REQ-038 Anti-windup and modes: out_max=100, kp=0x0100, error=+200 -> sat_hi=1 and the accumulator is frozen on subsequent positive errors; HOLD or P_ONLY with error=+5 -> accumulator unchanged.

Source files
------------

// File: rtl/lf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lf_pkg : shared mode encoding and default widths for the PI filter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lf_pkg;

    typedef enum logic [1:0] {
        MODE_PI     = 2'd0,
        MODE_P_ONLY = 2'd1,
        MODE_HOLD   = 2'd2,
        MODE_CLEAR  = 2'd3
    } lf_mode_e;

    localparam int c_ERR_W  = 16;
    localparam int c_ACC_W  = 24;
    localparam int c_K_INT  = 8;
    localparam int c_K_FRAC = 8;
    localparam int c_OUT_W  = 16;

endpackage
`default_nettype wire

// File: rtl/loop_filter_pi_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | loop_filter_pi_if : sample/control bus of the PI loop filter       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface loop_filter_pi_if
    import lf_pkg::*;
#(
    parameter int ERR_W  = c_ERR_W,
    parameter int K_INT  = c_K_INT,
    parameter int K_FRAC = c_K_FRAC,
    parameter int OUT_W  = c_OUT_W
);
    logic                            err_valid;
    logic signed [ERR_W-1:0]         error;
    logic signed [K_INT+K_FRAC-1:0]  kp;
    logic signed [K_INT+K_FRAC-1:0]  ki;
    lf_mode_e                        mode;
    logic        [OUT_W-1:0]         out_min;
    logic        [OUT_W-1:0]         out_max;
    logic        [OUT_W-1:0]         lf_out;
    logic                            lf_valid;
    logic                            sat_hi;
    logic                            sat_lo;
    logic                            acc_sat;

    modport master (
        output err_valid, error, kp, ki, mode, out_min, out_max,
        input  lf_out, lf_valid, sat_hi, sat_lo, acc_sat
    );

    modport slave (
        input  err_valid, error, kp, ki, mode, out_min, out_max,
        output lf_out, lf_valid, sat_hi, sat_lo, acc_sat
    );

endinterface
`default_nettype wire

// File: rtl/lf_clamp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lf_clamp : signed range clamp with truncated result and hit flags  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lf_clamp #(
    parameter int W  = 17,
    parameter int RW = 16
) (
    input  wire logic signed [W-1:0] val,
    input  wire logic signed [W-1:0] lo,
    input  wire logic signed [W-1:0] hi,
    output logic         [RW-1:0]    res,
    output logic                     hit_lo,
    output logic                     hit_hi
);

    // An inverted range resolves to the low bound.
    always_comb begin
        res    = val[RW-1:0];
        hit_lo = 1'b0;
        hit_hi = 1'b0;
        if ((lo > hi) || (val < lo)) begin
            res    = lo[RW-1:0];
            hit_lo = 1'b1;
        end else if (val > hi) begin
            res    = hi[RW-1:0];
            hit_hi = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/loop_filter_pi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | loop_filter_pi : two-stage PI loop filter with clamped output and  |
// |                  anti-windup saturating integrator                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module loop_filter_pi
    import lf_pkg::*;
#(
    parameter int ERR_W  = c_ERR_W,
    parameter int ACC_W  = c_ACC_W,
    parameter int K_INT  = c_K_INT,
    parameter int K_FRAC = c_K_FRAC,
    parameter int OUT_W  = c_OUT_W
) (
    input  wire logic       clk_ref,
    input  wire logic       n_rst,
    loop_filter_pi_if.slave bus
);

    localparam int c_GAIN_W = K_INT + K_FRAC;
    localparam int c_P_W    = ERR_W + c_GAIN_W;
    localparam int c_I_W    = ACC_W + c_GAIN_W;
    localparam int c_SUM_W  = ((c_P_W > c_I_W) ? c_P_W : c_I_W) + 1;
    localparam int c_AS_W   = ACC_W + 1;
    localparam logic signed [c_AS_W-1:0] c_ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [c_AS_W-1:0] c_ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    logic signed [c_P_W-1:0]   w_p;
    logic signed [c_P_W-1:0]   r_p;
    logic signed [c_I_W-1:0]   w_i;
    logic signed [c_I_W-1:0]   r_i;
    logic                      r_s1_valid;
    logic        [OUT_W-1:0]   r_min;
    logic        [OUT_W-1:0]   r_max;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [c_AS_W-1:0]  w_acc_sum;
    logic                      w_acc_hit_lo;
    logic                      w_acc_hit_hi;
    logic                      r_acc_sat;
    logic                      w_use_i;
    logic                      w_err_pos;
    logic                      w_err_neg;
    logic                      w_windup;
    logic signed [c_SUM_W-1:0] w_sum;
    logic signed [c_SUM_W-1:0] w_shift;
    logic signed [c_SUM_W-1:0] w_min_x;
    logic signed [c_SUM_W-1:0] w_max_x;
    logic        [OUT_W-1:0]   w_out;
    logic                      w_out_hi;
    logic                      w_out_lo;
    logic        [OUT_W-1:0]   r_lf_out;
    logic                      r_lf_valid;
    logic                      r_sat_hi;
    logic                      r_sat_lo;

    // Operands are sign-extended to the product width so the multiply is exact.
    assign w_p = $signed({{c_GAIN_W{bus.error[ERR_W-1]}}, bus.error})
               * $signed({{ERR_W{bus.kp[c_GAIN_W-1]}}, bus.kp});
    assign w_i = $signed({{c_GAIN_W{r_acc[ACC_W-1]}}, r_acc})
               * $signed({{ACC_W{bus.ki[c_GAIN_W-1]}}, bus.ki});

    assign w_use_i   = (bus.mode == MODE_PI) || (bus.mode == MODE_HOLD);
    assign w_err_neg = bus.error[ERR_W-1];
    assign w_err_pos = !w_err_neg && (bus.error != '0);
    assign w_windup  = (r_sat_hi && w_err_pos) || (r_sat_lo && w_err_neg);

    assign w_acc_sum = $signed({r_acc[ACC_W-1], r_acc})
                     + $signed({{(c_AS_W-ERR_W){bus.error[ERR_W-1]}}, bus.error});

    lf_clamp #(
        .W  (c_AS_W),
        .RW (ACC_W)
    ) u_acc_rail (
        .val    (w_acc_sum),
        .lo     (c_ACC_MIN),
        .hi     (c_ACC_MAX),
        .res    (w_acc_next),
        .hit_lo (w_acc_hit_lo),
        .hit_hi (w_acc_hit_hi)
    );

    // Bounds travel with the sample so a later bound change cannot alter it.
    always_ff @(posedge clk_ref or negedge n_rst) begin
        if (!n_rst) begin
            r_s1_valid <= 1'b0;
            r_p        <= '0;
            r_i        <= '0;
            r_min      <= '0;
            r_max      <= '0;
            r_acc      <= '0;
            r_acc_sat  <= 1'b0;
        end else begin
            r_s1_valid <= bus.err_valid;
            if (bus.err_valid) begin
                r_p   <= w_p;
                r_i   <= w_use_i ? w_i : '0;
                r_min <= bus.out_min;
                r_max <= bus.out_max;
                case (bus.mode)
                    MODE_PI: begin
                        if (!w_windup) begin
                            r_acc     <= w_acc_next;
                            r_acc_sat <= w_acc_hit_lo || w_acc_hit_hi
                                      || (w_acc_sum == c_ACC_MAX)
                                      || (w_acc_sum == c_ACC_MIN);
                        end
                    end
                    MODE_CLEAR: begin
                        r_acc     <= '0;
                        r_acc_sat <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_sum   = $signed({{(c_SUM_W-c_P_W){r_p[c_P_W-1]}}, r_p})
                   + $signed({{(c_SUM_W-c_I_W){r_i[c_I_W-1]}}, r_i});
    assign w_shift = w_sum >>> K_FRAC;
    assign w_min_x = $signed({{(c_SUM_W-OUT_W){1'b0}}, r_min});
    assign w_max_x = $signed({{(c_SUM_W-OUT_W){1'b0}}, r_max});

    lf_clamp #(
        .W  (c_SUM_W),
        .RW (OUT_W)
    ) u_out_clamp (
        .val    (w_shift),
        .lo     (w_min_x),
        .hi     (w_max_x),
        .res    (w_out),
        .hit_lo (w_out_lo),
        .hit_hi (w_out_hi)
    );

    always_ff @(posedge clk_ref or negedge n_rst) begin
        if (!n_rst) begin
            r_lf_valid <= 1'b0;
            r_lf_out   <= '0;
            r_sat_hi   <= 1'b0;
            r_sat_lo   <= 1'b0;
        end else begin
            r_lf_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_lf_out <= w_out;
                r_sat_hi <= w_out_hi;
                r_sat_lo <= w_out_lo;
            end
        end
    end

    assign bus.lf_out   = r_lf_out;
    assign bus.lf_valid = r_lf_valid;
    assign bus.sat_hi   = r_sat_hi;
    assign bus.sat_lo   = r_sat_lo;
    assign bus.acc_sat  = r_acc_sat;

endmodule
`default_nettype wire

// File: tb/tb_loop_filter_pi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_loop_filter_pi : vector table + scoreboard bench for the filter |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_loop_filter_pi;
    import lf_pkg::*;

    typedef struct {
        lf_mode_e mode;
        int       err;
        int       kp;
        int       ki;
        int       omin;
        int       omax;
        int       out;
        bit       hi;
        bit       lo;
    } vec_t;

    typedef struct {
        int out;
        bit hi;
        bit lo;
        int cyc;
    } exp_t;

    logic   clk_ref = 1'b0;
    logic   n_rst;
    int     cyc      = 0;
    int     n_checks = 0;
    int     n_fail   = 0;
    exp_t   sb[$];
    exp_t   mon_e;
    vec_t   vecs[17];

    loop_filter_pi_if bus ();

    loop_filter_pi dut (
        .clk_ref (clk_ref),
        .n_rst   (n_rst),
        .bus     (bus)
    );

    always #5 clk_ref = ~clk_ref;
    always @(posedge clk_ref) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(lf_mode_e m, int err, int kp, int ki, int omin, int omax,
                                int out, bit hi, bit lo);
        vec_t v;
        v.mode = m;   v.err  = err;  v.kp = kp; v.ki = ki;
        v.omin = omin; v.omax = omax; v.out = out; v.hi = hi; v.lo = lo;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        exp_t e;
        bus.err_valid = 1'b1;
        bus.mode      = v.mode;
        bus.error     = 16'(v.err);
        bus.kp        = 16'(v.kp);
        bus.ki        = 16'(v.ki);
        bus.out_min   = 16'(v.omin);
        bus.out_max   = 16'(v.omax);
        e.out = v.out; e.hi = v.hi; e.lo = v.lo; e.cyc = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic step(input vec_t v);
        @(negedge clk_ref);
        drive(v);
    endtask

    // Idle cycles carry a non-zero error and CLEAR mode that must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_ref);
            bus.err_valid = 1'b0;
            bus.mode      = MODE_CLEAR;
            bus.error     = 16'sd1234;
        end
    endtask

    always @(negedge clk_ref) begin
        if (bus.lf_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_lf_valid: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("lf_out",        bus.lf_out,  mon_e.out);
                check("sat_hi",        bus.sat_hi,  mon_e.hi);
                check("sat_lo",        bus.sat_lo,  mon_e.lo);
                check("lf_valid_cyc",  cyc,         mon_e.cyc);
            end
        end
    end

    initial begin
        n_rst         = 1'b1;
        bus.err_valid = 1'b0;
        bus.mode      = MODE_PI;
        bus.error     = '0;
        bus.kp        = '0;
        bus.ki        = '0;
        bus.out_min   = '0;
        bus.out_max   = 16'hFFFF;

        vecs[0]  = mk(MODE_PI,      100,   'h0100, 0,   0, 65535,   100, 0, 0);
        vecs[1]  = mk(MODE_PI,      -50,   'h0100, 0,   0, 65535,     0, 0, 1);
        vecs[2]  = mk(MODE_PI,      -50,   'h0100, 0,  10, 65535,    10, 0, 1);
        vecs[3]  = mk(MODE_PI,      200,   'h0100, 0,   0,   100,   100, 1, 0);
        vecs[4]  = mk(MODE_PI,      100,   'h0100, 0,   0,   100,   100, 0, 0);
        vecs[5]  = mk(MODE_PI,       10,   'h0100, 0,  10, 65535,    10, 0, 0);
        vecs[6]  = mk(MODE_PI,     1000,   'h0080, 0,   0, 65535,   500, 0, 0);
        vecs[7]  = mk(MODE_PI,        3,   'h0080, 0,   0, 65535,     1, 0, 0);
        vecs[8]  = mk(MODE_P_ONLY,    7,   'h0040, 0,   0, 65535,     1, 0, 0);
        vecs[9]  = mk(MODE_PI,       -1,   'h0001, 0,   0, 65535,     0, 0, 1);
        vecs[10] = mk(MODE_PI,      255,   'h0001, 0,   0, 65535,     0, 0, 0);
        vecs[11] = mk(MODE_PI,      100,   'h0100, 0, 500,   200,   500, 0, 1);
        vecs[12] = mk(MODE_PI,    32767,   'h7FFF, 0,   0, 65535, 65535, 1, 0);
        vecs[13] = mk(MODE_PI,     -100,   'hFF00, 0,   0, 65535,   100, 0, 0);
        vecs[14] = mk(MODE_HOLD,     42,   'h0100, 0,   0, 65535,    42, 0, 0);
        vecs[15] = mk(MODE_CLEAR,    10,   'h0200, 0,   0, 65535,    20, 0, 0);
        vecs[16] = mk(MODE_PI,     -100,   'h8000, 0,   0, 65535, 12800, 0, 0);

        #2 n_rst = 1'b0;
        repeat (2) @(negedge clk_ref);
        check("rst_lf_out",   bus.lf_out,   0);
        check("rst_lf_valid", bus.lf_valid, 0);
        check("rst_sat_hi",   bus.sat_hi,   0);
        check("rst_sat_lo",   bus.sat_lo,   0);
        check("rst_acc_sat",  bus.acc_sat,  0);
        check("rst_acc",      dut.r_acc,    0);
        n_rst = 1'b1;
        idle(2);

        foreach (vecs[k]) step(vecs[k]);
        idle(4);

        // Integral path from a cleared accumulator, then HOLD / P_ONLY freezing.
        step(mk(MODE_CLEAR, 0, 0, 0, 0, 65535, 0, 0, 0));
        idle(3);
        for (int k = 0; k < 4; k++) step(mk(MODE_PI, 16, 0, 'h10, 0, 65535, k, 0, 0));
        idle(4);
        check("acc_after_int", dut.r_acc, 64);
        step(mk(MODE_HOLD,    5, 0,      'h10, 0, 65535, 4, 0, 0));
        step(mk(MODE_P_ONLY,  5, 'h100,  'h10, 0, 65535, 5, 0, 0));
        idle(3);
        check("acc_hold_ponly", dut.r_acc, 64);
        step(mk(MODE_PI,      5, 0,      'h10, 0, 65535, 4, 0, 0));
        idle(3);
        check("acc_pi_resume", dut.r_acc, 69);

        // Integrator rail.
        step(mk(MODE_CLEAR, 0, 0, 0, 0, 65535, 0, 0, 0));
        idle(3);
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk_ref);
            if (k == 257) begin
                check("acc_256",     dut.r_acc,   8388352);
                check("acc_sat_256", bus.acc_sat, 0);
            end
            if (k == 258) begin
                check("acc_257",     dut.r_acc,   8388607);
                check("acc_sat_257", bus.acc_sat, 1);
            end
            drive(mk(MODE_PI, 32767, 0, 0, 0, 65535, 0, 0, 0));
        end
        idle(4);
        check("acc_rail",     dut.r_acc,   8388607);
        check("acc_sat_rail", bus.acc_sat, 1);
        step(mk(MODE_CLEAR, 0, 0, 0, 0, 65535, 0, 0, 0));
        idle(3);
        check("acc_clear",     dut.r_acc,   0);
        check("acc_sat_clear", bus.acc_sat, 0);

        // Anti-windup on both rails.
        step(mk(MODE_PI, 200, 'h100, 0, 0, 100, 100, 1, 0));
        idle(3);
        check("aw_first", dut.r_acc, 200);
        step(mk(MODE_PI, 200, 'h100, 0, 0, 100, 100, 1, 0));
        step(mk(MODE_PI,  50, 'h100, 0, 0, 100,  50, 0, 0));
        idle(3);
        check("aw_hi_frozen", dut.r_acc, 200);
        step(mk(MODE_PI, -20, 'h100, 0, 0, 100,   0, 0, 1));
        idle(3);
        check("aw_neg_update", dut.r_acc, 180);
        step(mk(MODE_PI, -20, 'h100, 0, 0, 100,   0, 0, 1));
        idle(3);
        check("aw_lo_frozen", dut.r_acc, 180);

        // Reset with a sample in flight.
        step(mk(MODE_PI, 200, 'h100, 0, 0, 100, 100, 1, 0));
        idle(3);
        step(mk(MODE_PI,  50, 'h100, 0, 0, 100,  50, 0, 0));
        @(negedge clk_ref);
        bus.err_valid = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        check("mid_rst_lf_out", bus.lf_out,   0);
        check("mid_rst_valid",  bus.lf_valid, 0);
        check("mid_rst_sat_hi", bus.sat_hi,   0);
        check("mid_rst_acc",    dut.r_acc,    0);
        sb.delete();
        repeat (2) @(negedge clk_ref);
        n_rst = 1'b1;
        idle(4);
        step(mk(MODE_PI, 77, 'h100, 0, 0, 65535, 77, 0, 0));
        idle(2);

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(negedge clk_ref);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
